// File: rtl/e_multicycle_sched.sv
// ---------------------------------------------------------------------------
// e_multicycle_sched
//
// Issue scheduler for the execute stage's two multi-cycle units (XALU for
// mult/div/mul with HI/LO, SALU for clo/clz). One operation is in flight at a
// time: it is accepted from D, started on its unit when that unit is free,
// its instruction context is carried opaquely while the unit runs, and the
// result plus context is presented to the E pipeline register. Flush,
// downstream-stall hold and a latency watchdog are included.
//
// Ports
//   Clk, reset        clock (rising edge), asynchronous active-low reset
//   flush             abort everything, highest priority
//   stall             downstream stall; holds a finished result in DONE
//   req_valid/unit/wb/ctx   request from D (unit: 0 = XALU, 1 = SALU;
//                     wb: 1 = GPR result expected, 0 = HI/LO only)
//   req_ready         request accepted this cycle
//   xalu_start/busy/lo, salu_start/busy/res   unit handshakes and results
//   unit_flush        abort to both units (flush or watchdog)
//   res_valid/data/ctx/timeout   completed op toward the E register
//   sched_busy        scheduler not idle; D must hold
// ---------------------------------------------------------------------------
module e_multicycle_sched #(
    parameter int CTX_W   = 96,
    parameter int MAX_LAT = 40
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             stall,
    input  logic             req_valid,
    input  logic             req_unit,
    input  logic             req_wb,
    input  logic [CTX_W-1:0] req_ctx,
    output logic             req_ready,
    output logic             xalu_start,
    input  logic             xalu_busy,
    input  logic [31:0]      xalu_lo,
    output logic             salu_start,
    input  logic             salu_busy,
    input  logic [31:0]      salu_res,
    output logic             unit_flush,
    output logic             res_valid,
    output logic [31:0]      res_data,
    output logic [CTX_W-1:0] res_ctx,
    output logic             res_timeout,
    output logic             sched_busy
);

    localparam int CNT_W = $clog2(MAX_LAT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               unit_q, unit_d;
    logic               wb_q, wb_d;
    logic [CTX_W-1:0]   ctx_q, ctx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_data_q, res_data_d;
    logic [CTX_W-1:0]   res_ctx_q, res_ctx_d;
    logic               res_timeout_q, res_timeout_d;
    logic               res_valid_q, res_valid_d;
    logic               sched_busy_q, sched_busy_d;

    logic               tgt_busy_s;
    logic [31:0]        tgt_res_s;
    logic               req_ready_s;
    logic               start_s;
    logic               wdog_s;

    assign tgt_busy_s = unit_q ? salu_busy : xalu_busy;
    assign tgt_res_s  = unit_q ? salu_res : xalu_lo;

    // Next-state, datapath capture and combinational handshakes.
    always_comb begin
        state_d       = state_q;
        unit_d        = unit_q;
        wb_d          = wb_q;
        ctx_d         = ctx_q;
        cnt_d         = cnt_q;
        res_data_d    = res_data_q;
        res_ctx_d     = res_ctx_q;
        res_timeout_d = res_timeout_q;
        req_ready_s   = 1'b0;
        start_s       = 1'b0;
        wdog_s        = 1'b0;

        if (flush) begin
            // Flush wins over everything: no accept, no start, no capture.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    req_ready_s = 1'b1;
                    if (req_valid) begin
                        unit_d  = req_unit;
                        wb_d    = req_wb;
                        ctx_d   = req_ctx;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    // A background mult/div may still own the unit.
                    start_s = !tgt_busy_s;
                    if (start_s) begin
                        if (wb_q) begin
                            state_d = S_WAIT;
                            cnt_d   = {CNT_W{1'b0}};
                        end else begin
                            // HI/LO-only op: the unit finishes on its own.
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Units raise busy one cycle after start, so busy is
                    // meaningless while the counter is still zero.
                    if ((cnt_q != {CNT_W{1'b0}}) && !tgt_busy_s) begin
                        res_data_d    = tgt_res_s;
                        res_ctx_d     = ctx_q;
                        res_timeout_d = 1'b0;
                        state_d       = S_DONE;
                    end else if (cnt_q == CNT_W'(MAX_LAT)) begin
                        wdog_s        = 1'b1;
                        res_data_d    = 32'd0;
                        res_ctx_d     = ctx_q;
                        res_timeout_d = 1'b1;
                        state_d       = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DONE: begin
                    if (stall) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        res_valid_d  = (state_d == S_DONE);
        sched_busy_d = (state_d != S_IDLE);
    end

    assign req_ready  = req_ready_s;
    assign xalu_start = start_s & ~unit_q;
    assign salu_start = start_s & unit_q;
    assign unit_flush = flush | wdog_s;

    assign res_valid   = res_valid_q;
    assign res_data    = res_data_q;
    assign res_ctx     = res_ctx_q;
    assign res_timeout = res_timeout_q;
    assign sched_busy  = sched_busy_q;

    // State, latched request fields, watchdog counter and result registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            unit_q        <= 1'b0;
            wb_q          <= 1'b0;
            ctx_q         <= {CTX_W{1'b0}};
            cnt_q         <= {CNT_W{1'b0}};
            res_data_q    <= 32'd0;
            res_ctx_q     <= {CTX_W{1'b0}};
            res_timeout_q <= 1'b0;
            res_valid_q   <= 1'b0;
            sched_busy_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            unit_q        <= unit_d;
            wb_q          <= wb_d;
            ctx_q         <= ctx_d;
            cnt_q         <= cnt_d;
            res_data_q    <= res_data_d;
            res_ctx_q     <= res_ctx_d;
            res_timeout_q <= res_timeout_d;
            res_valid_q   <= res_valid_d;
            sched_busy_q  <= sched_busy_d;
        end
    end

endmodule

// File: tb/tb_e_multicycle_sched.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for e_multicycle_sched. Inputs change 2 time
// units after the rising edge; outputs are sampled at the falling edge.
// Expected results are pushed when a wb=1 request is driven and popped when
// res_valid is seen.
// ---------------------------------------------------------------------------
module tb_e_multicycle_sched;

    localparam int CTX_W   = 96;
    localparam int MAX_LAT = 8;

    logic             Clk;
    logic             reset;
    logic             flush;
    logic             stall;
    logic             req_valid;
    logic             req_unit;
    logic             req_wb;
    logic [CTX_W-1:0] req_ctx;
    logic             req_ready;
    logic             xalu_start;
    logic             xalu_busy;
    logic [31:0]      xalu_lo;
    logic             salu_start;
    logic             salu_busy;
    logic [31:0]      salu_res;
    logic             unit_flush;
    logic             res_valid;
    logic [31:0]      res_data;
    logic [CTX_W-1:0] res_ctx;
    logic             res_timeout;
    logic             sched_busy;

    typedef struct packed {
        logic [31:0]      data;
        logic [CTX_W-1:0] ctx;
        logic             tout;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    e_multicycle_sched #(.CTX_W(CTX_W), .MAX_LAT(MAX_LAT)) dut (
        .Clk(Clk), .reset(reset), .flush(flush), .stall(stall),
        .req_valid(req_valid), .req_unit(req_unit), .req_wb(req_wb),
        .req_ctx(req_ctx), .req_ready(req_ready),
        .xalu_start(xalu_start), .xalu_busy(xalu_busy), .xalu_lo(xalu_lo),
        .salu_start(salu_start), .salu_busy(salu_busy), .salu_res(salu_res),
        .unit_flush(unit_flush), .res_valid(res_valid), .res_data(res_data),
        .res_ctx(res_ctx), .res_timeout(res_timeout), .sched_busy(sched_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctx(input string tag, input logic [CTX_W-1:0] obs, input logic [CTX_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge (input drive point).
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Move to the falling edge (sample point).
    task automatic smp();
        #3;
    endtask

    // Wait (bounded) for res_valid, check the latency in cycles, pop and compare.
    task automatic drain(input string tag, input int budget, input int exp_wait);
        int   n;
        exp_t e;
        n = 0;
        while (!res_valid && n < budget) begin
            tick();
            smp();
            n++;
        end
        chk_bit({tag, "_valid"}, res_valid, 1'b1);
        chk_int({tag, "_latency"}, n, exp_wait);
        chk_bit({tag, "_sb_nonempty"}, (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk_word({tag, "_data"}, res_data, e.data);
            chk_ctx({tag, "_ctx"}, res_ctx, e.ctx);
            chk_bit({tag, "_timeout"}, res_timeout, e.tout);
        end else begin
            chk_bit({tag, "_no_expect"}, res_valid, 1'b0);
        end
    endtask

    initial begin
        logic [CTX_W-1:0] ctx_a5;
        logic [CTX_W-1:0] ctx_b;
        logic [CTX_W-1:0] ctx_c;
        logic [CTX_W-1:0] ctx_d;
        logic [CTX_W-1:0] ctx_e;
        checks    = 0;
        errors    = 0;
        ctx_a5    = 96'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5;
        ctx_b     = 96'h0000_1111_2222_3333_4444_5555;
        ctx_c     = 96'hC0C0_0000_FFFF_0000_1234_5678;
        ctx_d     = 96'hDDDD_0001_0002_0003_0004_0005;
        ctx_e     = 96'hEEEE_9999_8888_7777_6666_5555;
        reset     = 1'b0;
        flush     = 1'b0;
        stall     = 1'b0;
        req_valid = 1'b0;
        req_unit  = 1'b0;
        req_wb    = 1'b0;
        req_ctx   = {CTX_W{1'b0}};
        xalu_busy = 1'b0;
        xalu_lo   = 32'd0;
        salu_busy = 1'b0;
        salu_res  = 32'd0;

        // ---------------- reset state ----------------
        tick();
        tick();
        smp();
        chk_bit("rst_req_ready", req_ready, 1'b1);
        chk_bit("rst_sched_busy", sched_busy, 1'b0);
        chk_bit("rst_res_valid", res_valid, 1'b0);
        chk_bit("rst_unit_flush", unit_flush, 1'b0);
        chk_bit("rst_xalu_start", xalu_start, 1'b0);
        chk_bit("rst_salu_start", salu_start, 1'b0);
        chk_word("rst_res_data", res_data, 32'd0);
        chk_ctx("rst_res_ctx", res_ctx, {CTX_W{1'b0}});
        chk_bit("rst_res_timeout", res_timeout, 1'b0);
        reset = 1'b1;

        // ---------------- basic SALU (clo) ----------------
        tick();
        req_valid = 1'b1; req_unit = 1'b1; req_wb = 1'b1; req_ctx = ctx_a5;
        salu_res  = 32'd7;
        sb.push_back('{data: 32'd7, ctx: ctx_a5, tout: 1'b0});
        smp();
        chk_bit("salu_accept", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        smp();
        chk_bit("salu_start_pulse", salu_start, 1'b1);
        chk_bit("salu_no_xstart", xalu_start, 1'b0);
        chk_bit("salu_busy_issue", sched_busy, 1'b1);
        // Unit busy for the three cycles following start.
        for (int i = 0; i < 3; i++) begin
            tick();
            salu_busy = 1'b1;
            smp();
            chk_bit("salu_start_single", salu_start, 1'b0);
            chk_bit("salu_busy_wait", sched_busy, 1'b1);
            chk_bit("salu_not_done", res_valid, 1'b0);
        end
        tick();
        salu_busy = 1'b0;
        smp();
        chk_bit("salu_capture_cycle", res_valid, 1'b0);
        drain("salu", 10, 1);
        chk_bit("salu_busy_done", sched_busy, 1'b1);
        tick();
        smp();
        chk_bit("salu_consumed", res_valid, 1'b0);
        chk_bit("salu_idle", sched_busy, 1'b0);

        // ---------------- background div then mul ----------------
        tick();
        req_valid = 1'b1; req_unit = 1'b0; req_wb = 1'b0; req_ctx = ctx_b;
        smp();
        chk_bit("div_accept", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        smp();
        chk_bit("div_start", xalu_start, 1'b1);
        // div runs in the background for 20 cycles; mul presented right away.
        tick();
        xalu_busy = 1'b1;
        req_valid = 1'b1; req_unit = 1'b0; req_wb = 1'b1; req_ctx = ctx_c;
        xalu_lo   = 32'h1234_5678;
        sb.push_back('{data: 32'h1234_5678, ctx: ctx_c, tout: 1'b0});
        smp();
        chk_bit("div_back_idle", sched_busy, 1'b0);
        chk_bit("mul_accept", req_ready, 1'b1);
        for (int i = 0; i < 19; i++) begin
            tick();
            req_valid = 1'b0;
            smp();
            chk_bit("mul_hold_issue", xalu_start, 1'b0);
        end
        tick();
        xalu_busy = 1'b0;
        smp();
        chk_bit("mul_start", xalu_start, 1'b1);
        tick();
        xalu_busy = 1'b1;
        smp();
        chk_bit("mul_start_single", xalu_start, 1'b0);
        tick();
        smp();
        tick();
        xalu_busy = 1'b0;
        smp();
        drain("mul", 10, 1);
        tick();
        smp();
        chk_bit("mul_idle", sched_busy, 1'b0);

        // ---------------- flush in WAIT ----------------
        tick();
        req_valid = 1'b1; req_unit = 1'b0; req_wb = 1'b1; req_ctx = ctx_d;
        smp();
        tick();
        req_valid = 1'b0;
        smp();
        chk_bit("fl_start", xalu_start, 1'b1);
        tick();
        xalu_busy = 1'b1;
        smp();
        tick();
        flush = 1'b1;
        req_valid = 1'b1; req_unit = 1'b1; req_wb = 1'b1; req_ctx = ctx_e;
        smp();
        chk_bit("fl_unit_flush", unit_flush, 1'b1);
        chk_bit("fl_no_ready", req_ready, 1'b0);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        xalu_busy = 1'b0;
        smp();
        chk_bit("fl_idle", sched_busy, 1'b0);
        chk_bit("fl_no_valid", res_valid, 1'b0);
        chk_bit("fl_unit_flush_off", unit_flush, 1'b0);
        tick();
        smp();
        chk_bit("fl_req_dropped", sched_busy, 1'b0);
        chk_bit("fl_no_salu_start", salu_start, 1'b0);

        // ---------------- stall hold ----------------
        tick();
        req_valid = 1'b1; req_unit = 1'b1; req_wb = 1'b1; req_ctx = ctx_e;
        salu_res  = 32'h0000_0055;
        sb.push_back('{data: 32'h0000_0055, ctx: ctx_e, tout: 1'b0});
        smp();
        tick();
        req_valid = 1'b0;
        smp();
        chk_bit("st_start", salu_start, 1'b1);
        tick();
        salu_busy = 1'b1;
        smp();
        tick();
        salu_busy = 1'b0;
        stall = 1'b1;
        smp();
        drain("stall", 10, 1);
        salu_res = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            smp();
            chk_bit("st_hold_valid", res_valid, 1'b1);
            chk_word("st_hold_data", res_data, 32'h0000_0055);
        end
        tick();
        stall = 1'b0;
        smp();
        chk_bit("st_last_valid", res_valid, 1'b1);
        tick();
        smp();
        chk_bit("st_released", res_valid, 1'b0);
        chk_bit("st_idle", sched_busy, 1'b0);

        // ---------------- watchdog ----------------
        tick();
        req_valid = 1'b1; req_unit = 1'b1; req_wb = 1'b1; req_ctx = ctx_b;
        sb.push_back('{data: 32'd0, ctx: ctx_b, tout: 1'b1});
        smp();
        tick();
        req_valid = 1'b0;
        smp();
        chk_bit("wd_start", salu_start, 1'b1);
        // WAIT cycles 1..8 elapse quietly; the pulse lands in the next one.
        for (int w = 1; w <= MAX_LAT + 1; w++) begin
            tick();
            salu_busy = 1'b1;
            smp();
            chk_bit("wd_pulse", unit_flush, (w == MAX_LAT + 1));
        end
        drain("wdog", 4, 1);
        tick();
        smp();
        chk_bit("wd_single_pulse", unit_flush, 1'b0);
        chk_bit("wd_idle", sched_busy, 1'b0);
        salu_busy = 1'b0;

        // ---------------- async reset mid-ISSUE ----------------
        tick();
        xalu_busy = 1'b1;
        req_valid = 1'b1; req_unit = 1'b0; req_wb = 1'b1; req_ctx = ctx_a5;
        smp();
        tick();
        req_valid = 1'b0;
        smp();
        chk_bit("ar_issue_blocked", xalu_start, 1'b0);
        chk_bit("ar_issue_busy", sched_busy, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        chk_bit("ar_req_ready", req_ready, 1'b1);
        chk_bit("ar_sched_busy", sched_busy, 1'b0);
        chk_bit("ar_res_valid", res_valid, 1'b0);
        chk_bit("ar_xalu_start", xalu_start, 1'b0);
        chk_bit("ar_unit_flush", unit_flush, 1'b0);
        chk_word("ar_res_data", res_data, 32'd0);
        chk_ctx("ar_res_ctx", res_ctx, {CTX_W{1'b0}});
        chk_bit("ar_res_timeout", res_timeout, 1'b0);
        xalu_busy = 1'b0;
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            smp();
            chk_bit("ar_no_start", xalu_start, 1'b0);
            chk_bit("ar_stays_idle", sched_busy, 1'b0);
        end

        chk_int("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "time limit");
    end

endmodule
